// File: rtl/seg7_pkg.sv
// Shared constants and types for the seg7_scan_mux scanner.
// The optional leading-zero blanking build is selected with SEG7_SCAN_LZ_BLANK_EN.
package seg7_pkg;

  localparam int PRESCALE_DEF  = 100000;
  localparam int BLANK_CYC_DEF = 16;
  localparam int N_DIGITS_DEF  = 4;

  localparam logic [N_DIGITS_DEF-1:0] ANODE_OFF = '1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_scan_mux_tick.sv
// Slot timebase for seg7_scan_mux: counts PRESCALE cycles per digit slot and
// flags the last cycle of a slot and of a frame.
module scan_tick_gen #(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             last_digit,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_end,
  output logic             frame_end
);

  assign slot_end  = (cnt == CNT_W'(PRESCALE - 1));
  assign frame_end = slot_end & last_digit;

  // slot counter, wraps to zero after PRESCALE-1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with blank interval and
// frame-synchronous display updates. Define SEG7_SCAN_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int PRESCALE  = PRESCALE_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF,
  parameter int N_DIGITS  = N_DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  output logic [3:0]            binary,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{ANODE_OFF[0]}};

  logic [CNT_W-1:0]      cnt;
  logic                  slot_end;
  logic                  frame_end;
  logic                  last_digit;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] pending;
  logic                  pend_valid;
  logic [4*N_DIGITS-1:0] shadow;
  logic [N_DIGITS-1:0]   suppress;
  scan_state_t           state;
  logic [N_DIGITS-1:0]   an_sel;
  logic [3:0]            nib_sel;
  logic                  sup_sel;
  logic [N_DIGITS-1:0]   an_d;
  logic [3:0]            binary_d;

  assign last_digit = (idx == IDX_W'(N_DIGITS - 1));

  scan_tick_gen #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .last_digit (last_digit),
    .cnt        (cnt),
    .slot_end   (slot_end),
    .frame_end  (frame_end)
  );

  // digit index advances once per slot
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (slot_end) begin
      idx <= last_digit ? '0 : idx + IDX_W'(1);
    end else begin
      idx <= idx;
    end
  end

  // double-buffered display word; shadow only changes on a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      pend_valid <= 1'b0;
      shadow     <= '0;
    end else if (frame_end) begin
      pend_valid <= 1'b0;
      if (load) begin
        shadow <= value;
      end else if (pend_valid) begin
        shadow <= pending;
      end else begin
        shadow <= shadow;
      end
    end else if (load) begin
      pending    <= value;
      pend_valid <= 1'b1;
    end else begin
      pend_valid <= pend_valid;
    end
  end

  // per-digit suppression mask for leading zeros
  always_comb begin
    suppress = '0;
`ifdef SEG7_SCAN_LZ_BLANK_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int k = N_DIGITS - 1; k > 0; k--) begin
        upper_zero  = upper_zero & (shadow[4*k +: 4] == 4'h0);
        suppress[k] = upper_zero;
      end
    end
`else
    suppress = '0;
`endif
  end

  // slot phase and next-output selection from (cnt, idx)
  always_comb begin
    state   = (cnt < CNT_W'(BLANK_CYC)) ? ST_BLANK : ST_DRIVE;
    an_sel  = AN_OFF;
    nib_sel = 4'h0;
    sup_sel = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      an_sel[k] = (idx == IDX_W'(k)) ? 1'b0 : 1'b1;
      nib_sel   = nib_sel | ((idx == IDX_W'(k)) ? shadow[4*k +: 4] : 4'h0);
      sup_sel   = sup_sel | ((idx == IDX_W'(k)) & suppress[k]);
    end
    an_d     = AN_OFF;
    binary_d = nib_sel;
    if (sup_sel) begin
      binary_d = 4'h0;
    end else if (state == ST_DRIVE) begin
      an_d = an_sel;
    end else begin
      an_d = AN_OFF;
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= AN_OFF;
      binary     <= 4'h0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      binary     <= binary_d;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (PRESCALE=8, BLANK_CYC=2, N_DIGITS=4).
// Honours SEG7_SCAN_LZ_BLANK_EN to expect leading-zero blanking.
module tb_seg7_scan_mux;

`ifdef SEG7_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  binary;
  logic [3:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .PRESCALE  (8),
    .BLANK_CYC (2),
    .N_DIGITS  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .binary     (binary),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // expected {an, binary, frame_tick} for displayed-frame cycle c of a word
  function automatic logic [8:0] exp_cyc(input logic [15:0] word, input int c);
    int          s;
    int          pos;
    logic        sup;
    logic [15:0] upper;
    logic [3:0]  an_e;
    logic [3:0]  bin_e;
    s     = c / 8;
    pos   = c % 8;
    upper = word >> (4 * s);
    sup   = LZ && (s > 0) && (upper == 16'h0000);
    bin_e = sup ? 4'h0 : upper[3:0];
    an_e  = (pos < 2 || sup) ? 4'hF : ~(4'b0001 << s);
    return {an_e, bin_e, (c == 31)};
  endfunction

  // monitor: one expected word per displayed frame, armed by frame_tick
  initial begin : monitor
    logic [15:0] word;
    int          c;
    bit          active;
    word   = 16'h0000;
    c      = 0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (active) begin
        check("frame_cycle", {7'h00, an, binary, frame_tick}, {7'h00, exp_cyc(word, c)});
        c++;
        if (c == 32) active = 1'b0;
      end
      if (frame_tick && !active && sb_q.size() > 0) begin
        word   = sb_q.pop_front();
        c      = 0;
        active = 1'b1;
      end
    end
  end

  task automatic wait_ft(input string what);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_tick && t < 100);
    check(what, {15'h0000, frame_tick}, 16'h0001);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic check_reset_state(input string what);
    check({what, "_an"}, {12'h000, an}, 16'h000F);
    check({what, "_binary"}, {12'h000, binary}, 16'h0000);
    check({what, "_tick"}, {15'h0000, frame_tick}, 16'h0000);
  endtask

  // first slot after reset release shows digit 0 of an all-zero word
  task automatic check_slot0();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("slot0_an", {12'h000, an}, (k < 2) ? 16'h000F : 16'h000E);
      check("slot0_binary", {12'h000, binary}, 16'h0000);
      check("slot0_tick", {15'h0000, frame_tick}, 16'h0000);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    sb_q.push_back(16'h0000);
    rst = 1'b0;
    check_slot0();

    wait_ft("tick_frame1");
    sb_q.push_back(16'h1234);
    repeat (10) @(negedge clk);
    pulse_load(16'h1234);

    wait_ft("tick_frame2");
    sb_q.push_back(16'h5678);
    repeat (5) @(negedge clk);
    pulse_load(16'hAAAA);
    repeat (6) @(negedge clk);
    pulse_load(16'h5678);

    wait_ft("tick_frame3");
    sb_q.push_back(16'hBEEF);
    repeat (31) @(negedge clk);
    pulse_load(16'hBEEF);
    check("tick_on_boundary", {15'h0000, frame_tick}, 16'h0001);

    sb_q.push_back(16'h0042);
    repeat (8) @(negedge clk);
    pulse_load(16'h0042);

    wait_ft("tick_frame5");
    sb_q.push_back(16'h0000);
    repeat (6) @(negedge clk);
    pulse_load(16'h0000);

    wait_ft("tick_frame6");
    wait_ft("tick_frame7");
    repeat (3) @(negedge clk);
    pulse_load(16'h9999);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midscan_reset");
    sb_q.push_back(16'h0000);
    rst = 1'b0;
    check_slot0();

    wait_ft("tick_after_reset");
    repeat (34) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexed scanner for a common-anode 4-digit 7-segment display. Sits directly upstream of the 7-segment decoder.
- Holds a display word of N_DIGITS hex nibbles and cycles through the digits.
- For each digit it presents one nibble on `binary` to the decoder and drives the matching active-low anode.
- Includes an anti-ghosting blank interval and tear-free, frame-synchronous updates.

Parameters:
- PRESCALE, 100000, clock cycles per digit slot (>= 2); gives a 1 kHz digit rate at 100 MHz.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off (< PRESCALE).
- N_DIGITS, 4, number of digits scanned.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures `value`.
- value  in  4*N_DIGITS  display word; nibble k goes to digit k (digit 0 = rightmost).
- binary  out  4  nibble feeding the decoder's `binary` input.
- an  out  N_DIGITS  anode enables, active-low.
- frame_tick  out  1  one-cycle pulse when a new frame starts.

Behaviour:
- Single clock `clk`; reset `rst` is synchronous, active-high. All state is updated on the `clk` rising edge.
- Reset values:
  - cnt = 0, idx = 0
  - pending = 0, shadow = 0
  - an = all ones
  - binary = 0
  - frame_tick = 0
- Reset asserted mid-scan returns all of the above to reset values on the next edge; a pending load is discarded.
- Slot counter `cnt` (ceil(log2 PRESCALE) bits) counts 0..PRESCALE-1, then wraps to 0.
- On wrap, `idx` advances by 1 modulo N_DIGITS (N_DIGITS-1 -> 0).
- State per slot:
  - BLANK while cnt < BLANK_CYC.
  - DRIVE while cnt >= BLANK_CYC.
- Outputs are registered, with one cycle latency from (cnt, idx):
  - BLANK: an = all ones.
  - DRIVE: an[idx] = 0, all other bits 1.
  - binary = shadow[4*idx +: 4] during both BLANK and DRIVE, so the decoder settles before the anode turns on.
- Load path:
  - load = 1 writes `value` into `pending` and sets a pending-valid flag.
  - A frame boundary is the edge where idx wraps N_DIGITS-1 -> 0. At that edge, if the flag is set, pending is copied to shadow and the flag is cleared.
  - load coinciding with a boundary edge: `value` goes straight into shadow and the flag stays clear.
  - Back-to-back loads within one frame: the last one wins.
- frame_tick = 1 for exactly the one cycle after each boundary edge; it never fires during reset.
- Slot length is PRESCALE cycles; a full frame is N_DIGITS*PRESCALE cycles.
- No combinational path exists from `load` or `value` to the outputs.

Optional Feature:
- Macro: SEG7_SCAN_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - A digit k > 0 is suppressed when shadow nibbles k..N_DIGITS-1 are all zero.
  - For a suppressed digit, `an` stays all ones for the whole slot and `binary` = 0.
  - Digit 0 is never suppressed.
- Undefined: every digit is driven, zeros included. Timing is identical in both builds.

Decomposition:
- Package `seg7_pkg`:
  - ANODE_OFF constant (all ones).
  - state enum {ST_BLANK, ST_DRIVE}.
  - Default parameter constants (PRESCALE_DEF, BLANK_CYC_DEF, N_DIGITS_DEF).
- One natural sub-module, `scan_tick_gen`:
  - Contains the PRESCALE counter and produces cnt, slot_end and frame_end.
  - seg7_scan_mux owns idx, the load buffering and the output registers.

Test Plan (bench: PRESCALE=8, BLANK_CYC=2, N_DIGITS=4; decoder instantiated on `binary`):
- Reset hold then release → an=1111, binary=0, frame_tick=0. Frame 0 shows digit 0, binary=0, an=1110 in slot cycles 2..7.
- load value=16'h1234 mid-frame → current frame is unchanged. From the next frame: slot 0 binary=4/an=1110, slot 1 binary=3/an=1101, slot 2 binary=2/an=1011, slot 3 binary=1/an=0111. Blank cycles 0..1 of each slot show an=1111.
- load 16'hAAAA then 16'h5678 in the same frame → next frame shows 8,7,6,5 and never A.
- load 16'hBEEF asserted exactly on the boundary edge → the frame starting at that edge shows F,E,E,B. frame_tick pulses once, 32 cycles apart.
- Assert rst in slot 2 DRIVE with a pending load → next edge gives an=1111, binary=0, idx=0. The pending value never appears.
- With SEG7_SCAN_LZ_BLANK_EN, load 16'h0042 → digits 3 and 2 keep an=1111 for the full slot; digits 1 and 0 show 4 and 2. With 16'h0000, only digit 0 shows 0.
